fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the 32-bit instruction words whose 10-bit header the decode stage's control unit consumes. It drives the program counter, issues in-order requests to instruction memory, buffers the responses in a small FIFO and presents them to decode with a valid/ready handshake. Branch redirects from execute flush in-flight fetches. The block sits between instruction memory and the fetch/decode pipeline register.

## Interface
- ADDR_W, 32, PC and memory address width
- RESET_PC, 0, first fetch address after reset
- DEPTH, 2, instruction buffer entries; also the outstanding-request cap (power of 2, ≥2)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address, word aligned
- imem_ready  in  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  in  1  response valid; responses in request order, ≥1 cycle after acceptance
- imem_rdata  in  32  instruction word
- br_taken  in  1  redirect strobe from execute
- br_target  in  ADDR_W  redirect address; bits [1:0] forced to 0
- dec_ready  in  1  decode accepts current instruction
- f_valid  out  1  f_instr/f_pc/f_header valid
- f_instr  out  32  instruction word
- f_pc  out  ADDR_W  address of f_instr
- f_header  out  10  f_instr[31:22]: op=[31:30], immSignal=[29], cmd=[28:24], [23:22] reserved

## Operation
- State machine: BOOT, RUN, FLUSH.
- BOOT: entered on reset; imem_req=0. One cycle, then RUN.
- RUN: imem_req=1 when (occupancy + outstanding) < DEPTH and br_taken=0. On acceptance: pc += 4, outstanding += 1. Occupancy does not count a same-cycle pop.
- Response with imem_rvalid in RUN: {imem_rdata, pc of that request} pushed to FIFO tail; outstanding -= 1. A per-entry PC queue (DEPTH deep) tracks request addresses.
- Pop: f_valid && dec_ready removes the head.
- br_taken (any state except BOOT): FIFO cleared, pc ← {br_target[ADDR_W-1:2],2'b00}, no request that cycle, drop_cnt ← outstanding − (imem_rvalid ? 1 : 0). If the result is 0, next state RUN; otherwise FLUSH.
- FLUSH: imem_req=0; each imem_rvalid is discarded and decrements drop_cnt; at 0, go to RUN. A new br_taken in FLUSH updates pc only and keeps the drop count.
- Priority: reset > br_taken > push/pop. A pop coinciding with br_taken is ignored.
- imem_rvalid with outstanding=0 and drop_cnt=0 is a protocol violation. The response is ignored and no counter underflows.
- pc wraps modulo 2^ADDR_W.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, f_valid=0, f_instr=0, f_pc=0, f_header=0. Outstanding, occupancy and drop_cnt are 0. State is BOOT.
- First request: cycle 1 after rst_n deasserts.
- Latency: request accepted in cycle N, response in N+k (k≥1), f_valid in N+k+1. FIFO outputs are registered; there is no bypass.
- Throughput: 1 instruction/cycle with k=1 and dec_ready held high.
- Redirect: f_valid=0 in the cycle after br_taken. The first target request goes out in that cycle if drop_cnt=0; otherwise it goes out in the cycle after the last discarded response.
- imem_addr is stable while imem_req=1 and imem_ready=0.
- Full: no requests issue; a push never occurs into a full FIFO because of the credit rule.
- Empty: f_valid=0; f_instr, f_pc and f_header hold their last values.

## Configuration
- FETCH_PERF_CNT_EN defined: adds three 32-bit saturating outputs, all cleared on reset:
  - perf_fetched: count of pops.
  - perf_stall: cycles with f_valid && !dec_ready.
  - perf_flushed: entries cleared plus responses discarded.
- FETCH_PERF_CNT_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset, imem_ready=1, k=1, dec_ready=1: requests go to 0,4,8,… from cycle 1. First f_valid is in cycle 3 with f_pc=0, then one instruction per cycle.
- dec_ready=0 for 10 cycles: exactly 2 requests issue. f_valid stays 1 and the f_pc=0 instruction is held. After release, order is 0,4,8 with no gap beyond refill.
- k=3 with 2 outstanding, br_taken with br_target=0x103: both late responses are discarded. imem_addr=0x100 after they return, and the next f_pc=0x100.
- br_taken in the same cycle as imem_rvalid and pop with 1 outstanding: drop_cnt=0, state goes straight to RUN, and the next request is the target.
- f_instr=0xA5C0_0000 is presented: f_header=0x297 (op=2, immSignal=1, cmd=0x05, reserved=3).
- With FETCH_PERF_CNT_EN defined and the scenario-3 stimulus: perf_flushed=2. With the same stimulus and the macro undefined, the design elaborates without the perf ports.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, in-order instruction-memory requests, response FIFO and decode handshake.
// Optional counters perf_fetched/perf_stall/perf_flushed exist only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              dec_ready,
  output logic              f_valid,
  output logic [31:0]       f_instr,
  output logic [ADDR_W-1:0] f_pc,
  output logic [9:0]        f_header
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0]     r_count, r_outst, r_drop, w_drop_nxt, w_occ, w_cnt_nxt;
  logic [PW-1:0]     r_rd, r_wr, r_pq_rd, r_pq_wr, w_rd_nxt;
  logic [ADDR_W-1:0] r_pc, r_f_pc;
  logic [31:0]       r_f_instr;
  logic [31:0]       r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
  logic [ADDR_W-1:0] r_pq         [DEPTH];
  logic              w_redirect, w_pop, w_push, w_req, w_acc;

  // A pop in the same cycle frees its credit, which is what sustains one instruction per cycle.
  assign w_redirect = br_taken && (r_state != BOOT);
  assign f_valid    = (r_count != '0);
  assign w_pop      = f_valid && dec_ready && !br_taken;
  assign w_occ      = r_count - CW'(w_pop);
  assign w_req      = (r_state == RUN) && !br_taken && ((w_occ + r_outst) < DEPTH_C);
  assign w_acc      = w_req && imem_ready;
  assign w_push     = (r_state == RUN) && !br_taken && imem_rvalid && (r_outst != '0);
  assign w_cnt_nxt  = w_occ + CW'(w_push);
  assign w_rd_nxt   = r_rd + PW'(w_pop);

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign f_instr   = r_f_instr;
  assign f_pc      = r_f_pc;
  assign f_header  = r_f_instr[31:22];

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    unique case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (br_taken) begin
          w_drop_nxt  = (imem_rvalid && (r_outst != '0)) ? r_outst - ONE_C : r_outst;
          w_state_nxt = (w_drop_nxt == '0) ? RUN : FLUSH;
        end
      end
      FLUSH: begin
        if (imem_rvalid && (r_drop != '0)) w_drop_nxt = r_drop - ONE_C;
        if (w_drop_nxt == '0) w_state_nxt = RUN;
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= BOOT;
      r_drop    <= '0;
      r_outst   <= '0;
      r_count   <= '0;
      r_pc      <= RESET_PC;
      r_rd      <= '0;
      r_wr      <= '0;
      r_pq_rd   <= '0;
      r_pq_wr   <= '0;
      r_f_instr <= '0;
      r_f_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_redirect) begin
        r_pc    <= br_target & ~ADDR_W'(3);
        r_outst <= '0;
        r_count <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
        r_pq_rd <= '0;
        r_pq_wr <= '0;
      end else begin
        if (w_acc) r_pc <= r_pc + ADDR_W'(4);
        r_outst <= r_outst + CW'(w_acc) - CW'(w_push);
        r_count <= w_cnt_nxt;
        r_rd    <= w_rd_nxt;
        if (w_push) r_wr <= r_wr + ONE_P;
        if (w_push) r_pq_rd <= r_pq_rd + ONE_P;
        if (w_acc) r_pq_wr <= r_pq_wr + ONE_P;
        // Output registers mirror the next FIFO head; with nothing left they keep the last word.
        if (w_cnt_nxt != '0) begin
          r_f_instr <= (w_occ == '0) ? imem_rdata       : r_fifo_instr[w_rd_nxt];
          r_f_pc    <= (w_occ == '0) ? r_pq[r_pq_rd]    : r_fifo_pc[w_rd_nxt];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr] <= imem_rdata;
      r_fifo_pc[r_wr]    <= r_pq[r_pq_rd];
    end
    if (w_acc) r_pq[r_pq_wr] <= r_pc;
  end

`ifdef FETCH_PERF_CNT_EN
  logic        w_discard;
  logic [31:0] r_perf_fetched, r_perf_stall, r_perf_flushed;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign w_discard = imem_rvalid &&
                     (((r_state == RUN) && br_taken && (r_outst != '0)) ||
                      ((r_state == FLUSH) && (r_drop != '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_flushed <= '0;
    end else begin
      r_perf_fetched <= sat_add(r_perf_fetched, 32'(w_pop));
      r_perf_stall   <= sat_add(r_perf_stall, 32'(f_valid && !dec_ready));
      r_perf_flushed <= sat_add(r_perf_flushed,
                                (w_redirect ? 32'(r_count) : 32'd0) + 32'(w_discard));
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a memory/stream reference model.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_ready, imem_rvalid, br_taken, dec_ready;
  logic [31:0] imem_rdata, br_target;
  logic        imem_req, f_valid;
  logic [31:0] imem_addr, f_instr, f_pc;
  logic [9:0]  f_header;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_flushed;
`endif

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target), .dec_ready(dec_ready),
    .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_header(f_header)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flushed(perf_flushed)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } rsp_t;

  rsp_t        q[$];
  int unsigned cyc_n, epoch, last_due, lat_lo, lat_hi;
  int unsigned inflight, ready_cnt, n_acc, n_fv;
  logic [31:0] exp_req_pc, exp_fpc;
  bit          boot;
  int unsigned n_total, n_pass;
  logic        s_req, s_fv;
  logic [31:0] s_addr, s_fpc;
  logic [9:0]  s_hdr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h200) return 32'hA5C0_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dec_ready = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    br_taken = 1'b0; br_target = '0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_fvalid", f_valid, 0);
    chk("rst_finstr", f_instr, 0);
    chk("rst_fpc", f_pc, 0);
    chk("rst_fheader", f_header, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    epoch = 0; last_due = 0; cyc_n = 0; inflight = 0; ready_cnt = 0; n_acc = 0; n_fv = 0;
    exp_req_pc = 32'h0; exp_fpc = 32'h0; boot = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
  task automatic cyc(input bit dr, input bit rdy, input bit br, input logic [31:0] tgt,
                     input bit spur);
    bit          rv, fresh, exp_fv, pop_m, exp_req;
    int unsigned stale, lat;
    rsp_t        e;
    rv    = (q.size() > 0) && (q[0].due <= cyc_n);
    fresh = rv && (q[0].epoch == epoch);
    stale = 0;
    foreach (q[i]) if (q[i].epoch != epoch) stale++;
    dec_ready = dr; imem_ready = rdy; br_taken = br; br_target = tgt;
    imem_rvalid = rv || (spur && (q.size() == 0));
    imem_rdata  = rv ? mem_word(q[0].addr) : 32'hFFFF_FFFF;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_fv = f_valid; s_fpc = f_pc; s_hdr = f_header;
    if (f_valid) n_fv++;
    exp_fv  = (ready_cnt != 0);
    pop_m   = exp_fv && dr && !br;
    exp_req = !boot && (stale == 0) && !br && ((inflight - (pop_m ? 1 : 0)) < DEPTH);
    chk("f_valid", f_valid, exp_fv);
    chk("imem_req", imem_req, exp_req);
    if (exp_req && imem_req) chk("imem_addr", imem_addr, exp_req_pc);
    if (exp_fv && f_valid) begin
      chk("f_pc", f_pc, exp_fpc);
      chk("f_instr", f_instr, mem_word(exp_fpc));
      chk("f_header", f_header, 32'(mem_word(exp_fpc) >> 22));
    end
    if (rv) void'(q.pop_front());
    if (br && !boot) begin
      epoch++;
      exp_req_pc = tgt & 32'hFFFF_FFFC;
      exp_fpc    = tgt & 32'hFFFF_FFFC;
      inflight   = 0;
      ready_cnt  = 0;
    end else begin
      if (imem_req && rdy) begin
        lat    = $urandom_range(lat_hi, lat_lo);
        e.addr = imem_addr;
        e.epoch = epoch;
        e.due  = (cyc_n + lat > last_due + 1) ? cyc_n + lat : last_due + 1;
        last_due = e.due;
        q.push_back(e);
        inflight++;
        n_acc++;
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (fresh) ready_cnt++;
      if (pop_m) begin
        ready_cnt--;
        inflight--;
        exp_fpc = exp_fpc + 32'd4;
      end
    end
    boot = 1'b0;
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    lat_lo = 1; lat_hi = 1;

    // Streaming with single-cycle memory and decode always ready.
    do_reset();
    cyc(1, 1, 0, 0, 0); chk("s1_boot_req", s_req, 0);
    cyc(1, 1, 0, 0, 0); chk("s1_c1_req", s_req, 1); chk("s1_c1_addr", s_addr, 32'h0);
    cyc(1, 1, 0, 0, 0); chk("s1_c2_addr", s_addr, 32'h4); chk("s1_c2_fv", s_fv, 0);
    n_fv = 0;
    cyc(1, 1, 0, 0, 0); chk("s1_c3_fv", s_fv, 1); chk("s1_c3_fpc", s_fpc, 32'h0);
    repeat (11) cyc(1, 1, 0, 0, 0);
    chk("s1_throughput", n_fv, 12);

    // Decode stalled: only DEPTH requests may issue and the head is held.
    do_reset();
    repeat (11) cyc(0, 1, 0, 0, 0);
    chk("s2_reqs", n_acc, 2); chk("s2_fv", s_fv, 1); chk("s2_fpc", s_fpc, 32'h0);
    repeat (10) cyc(1, 1, 0, 0, 0);

    // Redirect with two late responses outstanding.
    do_reset(); lat_lo = 3; lat_hi = 3;
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h103, 0);
    cyc(1, 1, 0, 0, 0); chk("s3_c4_req", s_req, 0);
    cyc(1, 1, 0, 0, 0); chk("s3_c5_req", s_req, 0);
    lat_lo = 1; lat_hi = 1;
    cyc(1, 1, 0, 0, 0); chk("s3_c6_req", s_req, 1); chk("s3_c6_addr", s_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("s3_perf_flushed", perf_flushed, 2);
`endif
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0); chk("s3_c8_fv", s_fv, 1); chk("s3_c8_fpc", s_fpc, 32'h100);

    // Redirect coinciding with a response and a pop, one request outstanding.
    do_reset();
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h200, 0); chk("s4_c3_fv", s_fv, 1);
    cyc(1, 1, 0, 0, 0);
    chk("s4_c4_req", s_req, 1); chk("s4_c4_addr", s_addr, 32'h200); chk("s4_c4_fv", s_fv, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("s4_c6_fpc", s_fpc, 32'h200); chk("s4_c6_hdr", 32'(s_hdr), 32'h297);

    // Response with nothing outstanding must be ignored; then a redirect that wraps the PC.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0); chk("s5_spur_fv", s_fv, 0);
    repeat (6) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'hFFFF_FFFA, 0);
    repeat (8) cyc(1, 1, 0, 0, 0);

    // Random traffic: variable latency, backpressure and redirects.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          dr, rdy, br;
      logic [31:0] tgt;
      dr  = ($urandom_range(3, 0) != 0);
      rdy = ($urandom_range(9, 0) < 7);
      br  = ($urandom_range(31, 0) == 0);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0))) : $urandom;
      cyc(dr, rdy, br, tgt, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
